fetch_decode_reg: RTL and testbench

Pipeline boundary between instruction fetch and decode in the pipelined core. It pairs each fetch address with its instruction word from the synchronous instruction memory, which returns data one cycle after the request. It presents a registered instruction, PC and PC+4 to decode. It honours decode stall and flush from the hazard unit, and a one-entry skid buffer keeps responses that land while decode is stalled.

---
 rtl/fetch_decode_reg_pkg.sv | 26 ++
 rtl/fetch_decode_if.sv | 28 ++
 rtl/fetch_skid_buf.sv | 47 ++++
 rtl/fetch_decode_reg.sv | 119 +++++++++++
 tb/tb_fetch_decode_reg.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_reg_pkg.sv
// Shared types and constants for the fetch/decode pipeline boundary.
package fetch_decode_reg_pkg;

    // Address and instruction width.
    localparam int W = 32;

    // Bubble instruction injected on flush or when no instruction is available.
    localparam logic [W-1:0] NOP = 32'h0000_0000;

    // Sequential PC step.
    localparam logic [W-1:0] PC_INCR = 32'd4;

    // One fetched instruction with its address. The skid buffer and the
    // decode registers both use this layout.
    typedef struct packed {
        logic         valid;
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } fetch_entry_t;

    // Fall-through address. The sum is truncated to W bits, so 0xFFFFFFFC wraps to 0.
    function automatic logic [W-1:0] pc_plus4(input logic [W-1:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Handshake/bus bundle between fetch, instruction memory, hazard unit and decode.
interface fetch_decode_if;
    import fetch_decode_reg_pkg::*;

    logic         StallD;
    logic         FlushD;
    logic [W-1:0] PCF;
    logic         ReqF;
    logic [W-1:0] ImemRdata;
    logic [W-1:0] InstrD;
    logic [W-1:0] PCD;
    logic [W-1:0] PCPlus4D;
    logic         ValidD;
    logic         OvfErr;

    // Environment side: fetch, memory and hazard unit drive; decode observes.
    modport master (
        output StallD, FlushD, PCF, ReqF, ImemRdata,
        input  InstrD, PCD, PCPlus4D, ValidD, OvfErr
    );

    // Pipeline register side.
    modport slave (
        input  StallD, FlushD, PCF, ReqF, ImemRdata,
        output InstrD, PCD, PCPlus4D, ValidD, OvfErr
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer. It holds a memory response that lands while decode is stalled.
// A push while the buffer is full and not being popped is dropped and reported on overflow.
module fetch_skid_buf
    import fetch_decode_reg_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         overflow
);

    fetch_entry_t entry_r;

    assign dout = entry_r;
    assign full = entry_r.valid;

    // Flag a push that cannot be accepted: the buffer is full and nothing drains it this cycle.
    always_comb begin
        overflow = 1'b0;
        if (push && entry_r.valid && !pop) begin
            overflow = 1'b1;
        end else begin
            overflow = 1'b0;
        end
    end

    // Entry storage. A simultaneous pop and push refills the slot, which keeps order intact.
    always_ff @(posedge CLK) begin
        if (RST) begin
            entry_r <= '0;
        end else if (clear) begin
            entry_r.valid <= 1'b0;
        end else if (push && (!entry_r.valid || pop)) begin
            entry_r <= din;
        end else if (pop) begin
            entry_r.valid <= 1'b0;
        end else begin
            entry_r <= entry_r;
        end
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// Fetch/decode pipeline register. It pairs each fetch address with the instruction word
// the synchronous memory returns one cycle later, and honours stall and flush from the
// hazard unit. A one-entry skid buffer catches a response that lands during a stall.
module fetch_decode_reg
    import fetch_decode_reg_pkg::*;
(
    input logic           CLK,
    input logic           RST,
    fetch_decode_if.slave bus
);

    // In-flight tracker: a request issued last cycle has its data on ImemRdata now.
    logic         pend_v_r;
    logic [W-1:0] pend_pc_r;

    // Decode-stage registers.
    fetch_entry_t d_r;
    logic [W-1:0] pcplus4_r;
    logic         ovf_err_r;

    // Skid buffer hookup.
    fetch_entry_t resp_s;
    fetch_entry_t skid_out_s;
    fetch_entry_t load_entry_s;
    logic         skid_clear_s;
    logic         skid_push_s;
    logic         skid_pop_s;
    logic         skid_full_s;
    logic         skid_ovf_s;

    fetch_skid_buf u_skid (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (skid_clear_s),
        .push     (skid_push_s),
        .pop      (skid_pop_s),
        .din      (resp_s),
        .dout     (skid_out_s),
        .full     (skid_full_s),
        .overflow (skid_ovf_s)
    );

    // Assemble the response that is present this cycle from the tracker and the memory data.
    always_comb begin
        resp_s       = '0;
        resp_s.valid = pend_v_r;
        resp_s.pc    = pend_pc_r;
        resp_s.instr = bus.ImemRdata;
    end

    // Skid control, in priority order: reset/flush empty it, a stall parks the response,
    // a normal cycle drains it and refills it with any response that is present.
    always_comb begin
        skid_clear_s = 1'b0;
        skid_push_s  = 1'b0;
        skid_pop_s   = 1'b0;
        if (RST || bus.FlushD) begin
            skid_clear_s = 1'b1;
        end else if (bus.StallD) begin
            skid_push_s = pend_v_r;
        end else if (skid_full_s) begin
            skid_pop_s  = 1'b1;
            skid_push_s = pend_v_r;
        end else begin
            skid_push_s = 1'b0;
            skid_pop_s  = 1'b0;
        end
    end

    // Pick what decode loads on an unstalled cycle. The skid holds the older entry, so it goes first.
    always_comb begin
        load_entry_s = '0;
        if (skid_full_s) begin
            load_entry_s = skid_out_s;
        end else begin
            load_entry_s = resp_s;
        end
    end

    // Tracker, decode registers and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_v_r  <= 1'b0;
            pend_pc_r <= '0;
            d_r       <= '0;
            pcplus4_r <= '0;
            ovf_err_r <= 1'b0;
        end else if (bus.FlushD) begin
            // Kill everything in flight, including a request issued this same cycle.
            pend_v_r  <= 1'b0;
            d_r.valid <= 1'b0;
            d_r.instr <= NOP;
        end else begin
            pend_v_r  <= bus.ReqF;
            pend_pc_r <= bus.PCF;
            if (bus.StallD) begin
                if (skid_ovf_s) begin
                    ovf_err_r <= 1'b1;
                end else begin
                    ovf_err_r <= ovf_err_r;
                end
            end else if (load_entry_s.valid) begin
                d_r       <= load_entry_s;
                pcplus4_r <= pc_plus4(load_entry_s.pc);
            end else begin
                // Bubble. PCD and PCPlus4D keep the last real instruction's values.
                d_r.valid <= 1'b0;
                d_r.instr <= NOP;
            end
        end
    end

    assign bus.InstrD   = d_r.instr;
    assign bus.PCD      = d_r.pc;
    assign bus.PCPlus4D = pcplus4_r;
    assign bus.ValidD   = d_r.valid;
    assign bus.OvfErr   = ovf_err_r;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg. Outputs are sampled 1 time unit after each
// rising edge, so each check sees the state that edge registered.
module tb_fetch_decode_reg;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fetch_decode_if bus ();

    fetch_decode_reg dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Packed view {ValidD, InstrD, PCD, PCPlus4D}.
    logic [96:0] out_s;
    logic [96:0] exp_r;
    assign out_s = {bus.ValidD, bus.InstrD, bus.PCD, bus.PCPlus4D};

    // Drive one cycle of inputs, then step past the rising edge.
    task automatic cyc(input logic rst, input logic req, input logic [31:0] pc,
                       input logic [31:0] rd, input logic st, input logic fl);
        RST           = rst;
        bus.ReqF      = req;
        bus.PCF       = pc;
        bus.ImemRdata = rd;
        bus.StallD    = st;
        bus.FlushD    = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b0, 96'h0};
        if (out_s !== exp_r) begin bad++; $display("FAIL reset_outputs got=%h want=%h", out_s, exp_r); end
        total++;
        if (bus.OvfErr !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.OvfErr); end
        total++;
    endtask

    task automatic test_streaming();
        cyc(1'b0, 1'b1, 32'h00, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b0, 96'h0};
        if (out_s !== exp_r) begin bad++; $display("FAIL stream_latency got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b1, 32'h04, 32'h20080005, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h20080005, 32'h00, 32'h04};
        if (out_s !== exp_r) begin bad++; $display("FAIL stream_0 got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b1, 32'h08, 32'h20090007, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h20090007, 32'h04, 32'h08};
        if (out_s !== exp_r) begin bad++; $display("FAIL stream_1 got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b1, 32'h0C, 32'h01095020, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h01095020, 32'h08, 32'h0C};
        if (out_s !== exp_r) begin bad++; $display("FAIL stream_2 got=%h want=%h", out_s, exp_r); end
        total++;
    endtask

    task automatic test_stall_skid();
        cyc(1'b0, 1'b1, 32'h10, 32'h00A01820, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h00A01820, 32'h0C, 32'h10};
        if (out_s !== exp_r) begin bad++; $display("FAIL stall_pre got=%h want=%h", out_s, exp_r); end
        total++;
        // Response for 0x10 lands in the first stalled cycle.
        cyc(1'b0, 1'b0, 32'h0, 32'hAC010004, 1'b1, 1'b0);
        if (out_s !== exp_r) begin bad++; $display("FAIL stall_hold1 got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0);
        if (out_s !== exp_r) begin bad++; $display("FAIL stall_hold3 got=%h want=%h", out_s, exp_r); end
        total++;
        if (bus.OvfErr !== 1'b0) begin bad++; $display("FAIL stall_ovf got=%b want=0", bus.OvfErr); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b1, 32'hAC010004, 32'h10, 32'h14};
        if (out_s !== exp_r) begin bad++; $display("FAIL stall_release got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b0, 32'h0, 32'h10, 32'h14};
        if (out_s !== exp_r) begin bad++; $display("FAIL stall_nodup got=%h want=%h", out_s, exp_r); end
        total++;
    endtask

    task automatic test_overflow();
        cyc(1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h24, 32'h8C020000, 1'b1, 1'b0);
        if (bus.OvfErr !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", bus.OvfErr); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h8C030004, 1'b1, 1'b0);
        if (bus.OvfErr !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", bus.OvfErr); end
        total++;
        exp_r = {1'b0, 32'h0, 32'h10, 32'h14};
        if (out_s !== exp_r) begin bad++; $display("FAIL ovf_hold got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h8C020000, 32'h20, 32'h24};
        if (out_s !== exp_r) begin bad++; $display("FAIL ovf_kept got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b0, 32'h0, 32'h20, 32'h24};
        if (out_s !== exp_r) begin bad++; $display("FAIL ovf_dropped got=%h want=%h", out_s, exp_r); end
        total++;
        if (bus.OvfErr !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.OvfErr); end
        total++;
    endtask

    task automatic test_flush_beats_stall();
        cyc(1'b0, 1'b1, 32'h2C, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h30, 32'h00221820, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h00221820, 32'h2C, 32'h30};
        if (out_s !== exp_r) begin bad++; $display("FAIL flush_pre got=%h want=%h", out_s, exp_r); end
        total++;
        // Response for 0x30 is parked in the skid.
        cyc(1'b0, 1'b0, 32'h0, 32'h00431020, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h40, 32'h0, 1'b1, 1'b1);
        exp_r = {1'b0, 32'h0, 32'h2C, 32'h30};
        if (out_s !== exp_r) begin bad++; $display("FAIL flush_bubble got=%h want=%h", out_s, exp_r); end
        total++;
        if (bus.OvfErr !== 1'b1) begin bad++; $display("FAIL flush_ovf_hold got=%b want=1", bus.OvfErr); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h10000003, 1'b0, 1'b0);
        if (out_s !== exp_r) begin bad++; $display("FAIL flush_discard got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        if (out_s !== exp_r) begin bad++; $display("FAIL flush_empty got=%h want=%h", out_s, exp_r); end
        total++;
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b1, 32'h70, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h74, 32'h20100001, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h78, 32'h20110002, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h20100001, 32'h70, 32'h74};
        if (out_s !== exp_r) begin bad++; $display("FAIL b2b_0 got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h20120003, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h20110002, 32'h74, 32'h78};
        if (out_s !== exp_r) begin bad++; $display("FAIL b2b_1 got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h20120003, 32'h78, 32'h7C};
        if (out_s !== exp_r) begin bad++; $display("FAIL b2b_2 got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_r = {1'b0, 32'h0, 32'h78, 32'h7C};
        if (out_s !== exp_r) begin bad++; $display("FAIL b2b_end got=%h want=%h", out_s, exp_r); end
        total++;
    endtask

    task automatic test_wrap();
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        if (bus.OvfErr !== 1'b0) begin bad++; $display("FAIL wrap_ovf_cleared got=%b want=0", bus.OvfErr); end
        total++;
        cyc(1'b0, 1'b1, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h12345678, 32'hFFFFFFFC, 32'h00000000};
        if (out_s !== exp_r) begin bad++; $display("FAIL wrap got=%h want=%h", out_s, exp_r); end
        total++;
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b1, 32'h50, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h54, 32'h20130004, 1'b1, 1'b0);
        // Force an overflow too, so the reset has a set flag to clear.
        cyc(1'b0, 1'b1, 32'h58, 32'h20150006, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'h5C, 32'h20160007, 1'b1, 1'b0);
        exp_r = {1'b0, 96'h0};
        if (out_s !== exp_r) begin bad++; $display("FAIL rstmid_outputs got=%h want=%h", out_s, exp_r); end
        total++;
        if (bus.OvfErr !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b want=0", bus.OvfErr); end
        total++;
        cyc(1'b0, 1'b1, 32'h60, 32'hDEAD0000, 1'b0, 1'b0);
        if (out_s !== exp_r) begin bad++; $display("FAIL rstmid_clean got=%h want=%h", out_s, exp_r); end
        total++;
        cyc(1'b0, 1'b0, 32'h0, 32'h20140005, 1'b0, 1'b0);
        exp_r = {1'b1, 32'h20140005, 32'h60, 32'h64};
        if (out_s !== exp_r) begin bad++; $display("FAIL rstmid_first got=%h want=%h", out_s, exp_r); end
        total++;
    endtask

    initial begin
        bus.ReqF      = 1'b0;
        bus.PCF       = 32'h0;
        bus.ImemRdata = 32'h0;
        bus.StallD    = 1'b0;
        bus.FlushD    = 1'b0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_overflow();
        test_flush_beats_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
